tinker_exec_unit: RTL
=====================

TINKER_EXEC_UNIT -- requirements
Module: tinker_exec_unit

Interface
REQ-001 Parameter XLEN, default 64, meaning datapath and register width; legal values 8, 16, 32, 64.
REQ-002 Parameter NREGS, default 32, meaning number of architectural registers; legal values 2..32, power of two.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port in_valid  input  1  instruction offered.
REQ-006 Port instruction  input  32  fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], L[11:0].
REQ-007 Port in_ready  output  1  unit can accept an instruction.
REQ-008 Port done  output  1  one-cycle pulse marking instruction retirement.
REQ-009 Port illegal  output  1  qualifies done: retired instruction was unsupported; no register was written.
REQ-010 Port result  output  XLEN  value computed by the retired instruction; 0 when illegal.
REQ-011 Port dbg_addr  input  5  debug register read index.
REQ-012 Port dbg_data  output  XLEN  combinational read of R[dbg_addr]; 0 if dbg_addr >= NREGS.

Function
REQ-013 The unit SHALL hold NREGS clocked XLEN-bit registers; R0 SHALL read 0, and writes to it SHALL be discarded.
REQ-014 FSM states: IDLE, EXEC, DIV. in_ready SHALL be 1 only in IDLE.
REQ-015 Accept is in_valid && in_ready at a clk edge: latch instruction; IDLE->EXEC. in_valid outside IDLE SHALL be ignored.
REQ-016 Operand fetch (EXEC): A=R[rs], B=R[rt] for register forms; A=R[rd], B=zero-extended L for immediate forms (addi, subi, shftri, shftli).
REQ-017 Supported opcodes: 0x00 and, 0x01 or, 0x02 xor, 0x03 not (~A), 0x04 shftr, 0x05 shftri, 0x06 shftl, 0x07 shftli, 0x11 mov rd,rs (A), 0x12 mov rd,L (zero-extended L), 0x18 add, 0x19 addi, 0x1A sub, 0x1B subi, 0x1C mul, 0x1D div.
REQ-018 Arithmetic SHALL be unsigned, modulo 2^XLEN; mul SHALL return the low XLEN bits of the product.
REQ-019 Shifts SHALL be logical; the shift amount is B[log2(XLEN)-1:0].
REQ-020 All other opcodes, including float 0x14-0x17, and any rd/rs/rt index >= NREGS SHALL be illegal.
REQ-021 EXEC edge, non-div or illegal: write rd (legal only), load result, pulse done (and illegal if applicable) for the following cycle, ->IDLE. Accept-to-done latency: 2 edges.
REQ-022 EXEC edge, div with B != 0: ->DIV; restoring division, one quotient bit per edge, XLEN edges. On the last DIV edge: write quotient to rd, pulse done, ->IDLE. Latency: XLEN+2 edges.
REQ-023 div with B == 0 SHALL take the REQ-021 path with result 0 written to rd.
REQ-024 Back-to-back: in_ready is high during the done cycle; an instruction accepted then SHALL read the just-written register value.
REQ-025 done and illegal SHALL be 0 on every cycle other than the single retirement cycle; result SHALL hold its value until the next retirement.

Reset
REQ-026 reset SHALL force: state IDLE, all registers 0, done=0, illegal=0, result=0, in_ready=1 on the following cycle.
REQ-027 reset asserted in EXEC or DIV SHALL abort the instruction: no register write, no done pulse.
REQ-028 reset SHALL take priority over a simultaneous accept; that instruction SHALL be dropped.

Verification
REQ-029 mov r1,L=0x0FF; add r2,r1,r1 -> done 2 edges after each accept; result 0x1FE; dbg R2=0x1FE.
REQ-030 R1=100, R2=7; div r3,r1,r2 -> done exactly XLEN+2 edges after accept; R3=14. div r4,r1,r0 -> 2 edges; R4=0.
REQ-031 XLEN=64, R1=0xFFFF_FFFF_FFFF_FFFF; addi r1,1 -> R1=0; shftli r1 with L=63, R1 initially 1 -> 0x8000_0000_0000_0000.
REQ-032 opcode 0x14 (addf) or mov r0,L=5 -> addf: done=1, illegal=1, result=0, no register changes; mov r0: R0 still 0.
REQ-033 reset asserted on the 10th DIV edge -> no done pulse, all registers 0, in_ready=1 on the next cycle.
REQ-034 NREGS=8: add r9,r1,r2 -> illegal=1; held in_valid with a stream of 4 adds -> each accepted only in IDLE, one done per instruction, no instruction lost or duplicated.

Source files
------------

// File: rtl/tinker_exec_unit.sv
// tinker_exec_unit: single-issue integer execute unit with a private register file.
// One instruction at a time; divide iterates one quotient bit per cycle.
module tinker_exec_unit #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     instruction,
  output logic            in_ready,
  output logic            done,
  output logic            illegal,
  output logic [XLEN-1:0] result,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam int SW = $clog2(XLEN);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV
  } state_t;

  state_t          state_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [SW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            illegal_q;

  logic [4:0]      op;
  logic [4:0]      rd;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [XLEN-1:0] imm;
  logic            is_imm;
  logic            is_div;
  logic            op_ok;
  logic            idx_ok;
  logic            legal;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic            ge;

  assign op  = instr_q[31:27];
  assign rd  = instr_q[26:22];
  assign rs  = instr_q[21:17];
  assign rt  = instr_q[16:12];
  assign imm = XLEN'(instr_q[11:0]);

  assign is_imm = (op == 5'h05) || (op == 5'h07)
               || (op == 5'h19) || (op == 5'h1B);
  assign is_div = (op == 5'h1D);

  assign idx_ok = (32'(rd) < NREGS) && (32'(rs) < NREGS)
               && (32'(rt) < NREGS);
  assign legal  = op_ok && idx_ok;

  assign op_a = is_imm ? regs_q[rd[AW-1:0]] : regs_q[rs[AW-1:0]];
  assign op_b = is_imm ? imm : regs_q[rt[AW-1:0]];

  always_comb begin
    op_ok   = 1'b1;
    alu_res = '0;
    unique case (op)
      5'h00: alu_res = op_a & op_b;
      5'h01: alu_res = op_a | op_b;
      5'h02: alu_res = op_a ^ op_b;
      5'h03: alu_res = ~op_a;
      5'h04,
      5'h05: alu_res = op_a >> op_b[SW-1:0];
      5'h06,
      5'h07: alu_res = op_a << op_b[SW-1:0];
      5'h11: alu_res = op_a;
      5'h12: alu_res = imm;
      5'h18,
      5'h19: alu_res = op_a + op_b;
      5'h1A,
      5'h1B: alu_res = op_a - op_b;
      5'h1C: alu_res = op_a * op_b;
      5'h1D: alu_res = '0;
      default: op_ok = 1'b0;
    endcase
  end

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  assign ge    = ~trial[XLEN];
  assign rem_d = ge ? trial[XLEN-1:0]
                    : {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign quo_d = {quo_q[XLEN-2:0], ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            instr_q <= instruction;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (legal && is_div && (op_b != '0)) begin
            quo_q   <= op_a;
            rem_q   <= '0;
            dvs_q   <= op_b;
            cnt_q   <= '0;
            state_q <= DIV;
          end else begin
            done_q    <= 1'b1;
            illegal_q <= ~legal;
            result_q  <= legal ? alu_res : '0;
            if (legal && (rd != 5'd0))
              regs_q[rd[AW-1:0]] <= alu_res;
            state_q <= IDLE;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SW'(XLEN - 1)) begin
            done_q   <= 1'b1;
            result_q <= quo_d;
            if (rd != 5'd0)
              regs_q[rd[AW-1:0]] <= quo_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign result   = result_q;
  assign dbg_data = (32'(dbg_addr) < NREGS)
                  ? regs_q[dbg_addr[AW-1:0]] : '0;

endmodule
